// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: master FSM state encoding and response codes.
package axi_lite_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR    = 3'd1,
        S_WRESP = 3'd2,
        S_RD    = 3'd3,
        S_RDATA = 3'd4
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // SLVERR and DECERR both have bit 1 set.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: turns single-word user commands into one outstanding AXI4-Lite
// transaction and reports completion with a one-cycle response pulse.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int unsigned C_ADDR_WIDTH = 32
) (
    input  logic                    aclk,
    input  logic                    aresetn,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [C_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]             cmd_wdata,
    input  logic [3:0]              cmd_wstrb,

    output logic                    resp_valid,
    output logic [31:0]             resp_rdata,
    output logic [1:0]              resp_resp,
    output logic                    resp_err,

    output logic [C_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [31:0]             m_axi_wdata,
    output logic [3:0]              m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [C_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [31:0]             m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    state_t state;
    logic   aw_done;
    logic   w_done;
    logic   aw_fire;
    logic   w_fire;

    assign aw_fire   = m_axi_awvalid & m_axi_awready;
    assign w_fire    = m_axi_wvalid & m_axi_wready;
    assign cmd_ready = (state == S_IDLE) & aresetn;
    assign resp_err  = resp_is_err(resp_resp);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state         <= S_IDLE;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_araddr  <= '0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_resp     <= RESP_OKAY;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_write) begin
                            m_axi_awaddr  <= cmd_addr;
                            m_axi_wdata   <= cmd_wdata;
                            m_axi_wstrb   <= cmd_wstrb;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            aw_done       <= 1'b0;
                            w_done        <= 1'b0;
                            state         <= S_WR;
                        end else begin
                            m_axi_araddr  <= cmd_addr;
                            m_axi_arvalid <= 1'b1;
                            state         <= S_RD;
                        end
                    end
                end
                S_WR: begin
                    // AW and W complete independently; leave once both have fired.
                    if (aw_fire) m_axi_awvalid <= 1'b0;
                    if (w_fire)  m_axi_wvalid  <= 1'b0;
                    aw_done <= aw_done | aw_fire;
                    w_done  <= w_done | w_fire;
                    if ((aw_done | aw_fire) & (w_done | w_fire)) begin
                        m_axi_bready <= 1'b1;
                        state        <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        resp_valid   <= 1'b1;
                        resp_rdata   <= '0;
                        resp_resp    <= m_axi_bresp;
                        state        <= S_IDLE;
                    end
                end
                S_RD: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        resp_valid   <= 1'b1;
                        resp_rdata   <= m_axi_rdata;
                        resp_resp    <= m_axi_rresp;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: behavioural AXI4-Lite slave with programmable wait states,
// a word-array reference model and directed plus randomized command sequences.
module tb_axi_lite_master;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_resp;
    logic        resp_err;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
    logic [31:0] m_axi_rdata = '0;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
    logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_arready = 1'b0;
    logic        m_axi_bvalid = 1'b0, m_axi_rvalid = 1'b0;
    logic [1:0]  m_axi_bresp = '0, m_axi_rresp = '0;

    always #5 aclk = ~aclk;

    axi_lite_master #(.C_ADDR_WIDTH(32)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_resp(resp_resp),
        .resp_err(resp_err),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    // Slave configuration, set by the stimulus between commands.
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
    logic        r_force_en = 1'b0;
    logic [31:0] r_force_data = '0;
    int          n_b = 0;

    logic [31:0] s_mem [int unsigned];
    logic [31:0] ref_mem [int unsigned];

    // Slave state; handshakes at a rising edge are retired at the following falling edge.
    logic        got_aw = 0, got_w = 0, b_pend = 0, r_pend = 0;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    logic [31:0] s_awaddr = '0, s_wdata = '0, s_rdata = '0, p_awaddr = '0, p_araddr = '0;
    logic [31:0] p_wdata = '0, cur = '0;
    logic [3:0]  s_wstrb = '0, p_wstrb = '0;
    logic        p_awvalid = 0, p_wvalid = 0, p_bready = 0, p_arvalid = 0, p_rready = 0;

    always @(negedge aclk) begin
        if (!aresetn) begin
            m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
            m_axi_bvalid = 0; m_axi_rvalid = 0;
            got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
            p_awvalid = 0; p_wvalid = 0; p_bready = 0; p_arvalid = 0; p_rready = 0;
        end else begin
            if (p_awvalid && m_axi_awready) begin got_aw = 1; s_awaddr = p_awaddr; end
            if (p_wvalid && m_axi_wready) begin got_w = 1; s_wdata = p_wdata; s_wstrb = p_wstrb; end
            if (p_bready && m_axi_bvalid) begin m_axi_bvalid = 0; b_pend = 0; n_b++; end
            if (p_rready && m_axi_rvalid) begin m_axi_rvalid = 0; r_pend = 0; end
            if (p_arvalid && m_axi_arready) begin
                r_pend = 1; r_cnt = 0;
                if (r_force_en) s_rdata = r_force_data;
                else s_rdata = s_mem.exists(p_araddr >> 2) ? s_mem[p_araddr >> 2] : 32'h0;
            end
            if (got_aw && got_w) begin
                cur = s_mem.exists(s_awaddr >> 2) ? s_mem[s_awaddr >> 2] : 32'h0;
                for (int b = 0; b < 4; b++) if (s_wstrb[b]) cur[8*b +: 8] = s_wdata[8*b +: 8];
                s_mem[s_awaddr >> 2] = cur;
                got_aw = 0; got_w = 0; b_pend = 1; b_cnt = 0;
            end
            if (b_pend && !m_axi_bvalid) begin
                if (b_cnt >= b_dly) begin m_axi_bvalid = 1; m_axi_bresp = b_resp_cfg; end
                else b_cnt++;
            end
            if (r_pend && !m_axi_rvalid) begin
                if (r_cnt >= r_dly) begin
                    m_axi_rvalid = 1; m_axi_rdata = s_rdata; m_axi_rresp = r_resp_cfg;
                end else r_cnt++;
            end
            if (m_axi_awvalid) begin
                if (aw_cnt >= aw_dly) m_axi_awready = 1; else begin m_axi_awready = 0; aw_cnt++; end
            end else begin m_axi_awready = 0; aw_cnt = 0; end
            if (m_axi_wvalid) begin
                if (w_cnt >= w_dly) m_axi_wready = 1; else begin m_axi_wready = 0; w_cnt++; end
            end else begin m_axi_wready = 0; w_cnt = 0; end
            if (m_axi_arvalid) begin
                if (ar_cnt >= ar_dly) m_axi_arready = 1; else begin m_axi_arready = 0; ar_cnt++; end
            end else begin m_axi_arready = 0; ar_cnt = 0; end
            p_awvalid = m_axi_awvalid; p_awaddr = m_axi_awaddr;
            p_wvalid = m_axi_wvalid; p_wdata = m_axi_wdata; p_wstrb = m_axi_wstrb;
            p_arvalid = m_axi_arvalid; p_araddr = m_axi_araddr;
            p_bready = m_axi_bready; p_rready = m_axi_rready;
        end
    end

    int n_checks = 0, n_pass = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge aclk);
        #1;
    endtask

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a >> 2) ? ref_mem[a >> 2] : 32'h0;
    endfunction

    // Expected resp_rdata for a command; writes update the reference memory.
    function automatic logic [31:0] predict(input logic wr, input logic [31:0] a,
                                            input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        if (!wr) return ref_rd(a);
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        ref_mem[a >> 2] = (ref_rd(a) & ~m) | (d & m);
        return 32'h0;
    endfunction

    logic        av_hist [0:255];
    logic        wv_hist [0:255];
    int          got_lat, v_stable, v_rready, v_cmdrdy;
    logic        timed_out;
    logic [31:0] got_rdata;
    logic [1:0]  got_resp;
    logic        got_err;

    task automatic do_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
        int k = 0;
        while (!cmd_ready && k < 50) begin tick(); k++; end
        cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
        v_stable = 0; v_rready = 0; v_cmdrdy = 0;
        tick();
        cmd_valid = 1'b0;
        got_lat = 1;
        while (!resp_valid && got_lat < 200) begin
            av_hist[got_lat] = m_axi_awvalid;
            wv_hist[got_lat] = m_axi_wvalid;
            if (m_axi_awvalid && m_axi_awaddr !== a) v_stable++;
            if (m_axi_wvalid && (m_axi_wdata !== d || m_axi_wstrb !== s)) v_stable++;
            if (m_axi_arvalid && m_axi_araddr !== a) v_stable++;
            if (!wr && got_lat > 1 && !m_axi_arvalid && !m_axi_rready) v_rready++;
            if (cmd_ready) v_cmdrdy++;
            tick();
            got_lat++;
        end
        timed_out = !resp_valid;
        got_rdata = resp_rdata; got_resp = resp_resp; got_err = resp_err;
    endtask

    task automatic run_check(input string tag, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s,
                             input logic [31:0] exp_rdata, input logic [1:0] exp_resp,
                             input int exp_lat);
        do_cmd(wr, a, d, s);
        check({tag, " timeout"}, 32'(timed_out), 32'd0);
        check({tag, " rdata"}, got_rdata, exp_rdata);
        check({tag, " resp"}, 32'(got_resp), 32'(exp_resp));
        check({tag, " err"}, 32'(got_err), 32'(exp_resp[1]));
        check({tag, " latency"}, 32'(got_lat), 32'(exp_lat));
        check({tag, " stable"}, 32'(v_stable), 32'd0);
        tick();
        check({tag, " single pulse"}, 32'(resp_valid), 32'd0);
    endtask

    logic [31:0] e, ra, rd;
    logic [3:0]  rs;
    logic        rw;
    int          nb0;
    logic [31:0] eq_rdata [$];
    logic [1:0]  eq_resp [$];
    logic        bw [4];
    logic [31:0] ba [4], bd [4];
    logic [3:0]  bs [4];

    initial begin
        // Reset state
        cmd_valid = 1'b1;
        repeat (3) tick();
        check("rst cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                                 m_axi_rready, resp_valid}), 32'd0);
        check("rst awaddr", m_axi_awaddr, 32'd0);
        check("rst araddr", m_axi_araddr, 32'd0);
        check("rst wdata", m_axi_wdata, 32'd0);
        check("rst wstrb", 32'(m_axi_wstrb), 32'd0);
        check("rst resp", {resp_rdata[29:0], resp_resp}, 32'd0);
        cmd_valid = 1'b0;
        aresetn = 1'b1;
        tick();
        check("idle cmd_ready", 32'(cmd_ready), 32'd1);

        // Zero-wait write then read back
        e = predict(1'b1, 32'h04, 32'hDEADBEEF, 4'hF);
        run_check("wr04", 1'b1, 32'h04, 32'hDEADBEEF, 4'hF, e, 2'b00, 3);
        check("wr04 aw c1", 32'({av_hist[1], wv_hist[1]}), 32'd3);
        check("wr04 aw c2", 32'({av_hist[2], wv_hist[2]}), 32'd0);
        run_check("rd04", 1'b0, 32'h04, 0, 0, 32'hDEADBEEF, 2'b00, 3);

        // Strobed write merge
        e = predict(1'b1, 32'h00, 32'h11223344, 4'hF);
        run_check("wr00a", 1'b1, 32'h00, 32'h11223344, 4'hF, e, 2'b00, 3);
        e = predict(1'b1, 32'h00, 32'hAABBCCDD, 4'h5);
        run_check("wr00b", 1'b1, 32'h00, 32'hAABBCCDD, 4'h5, e, 2'b00, 3);
        run_check("rd00", 1'b0, 32'h00, 0, 0, 32'h11BB33DD, 2'b00, 3);

        // Independent AW/W: address late, then data late
        aw_dly = 3; nb0 = n_b;
        e = predict(1'b1, 32'h08, 32'hCAFEF00D, 4'hF);
        run_check("awlate", 1'b1, 32'h08, 32'hCAFEF00D, 4'hF, e, 2'b00, 6);
        check("awlate w drop", 32'({wv_hist[1], wv_hist[2]}), 32'd2);
        check("awlate aw hold", 32'({av_hist[2], av_hist[3], av_hist[4], av_hist[5]}), 32'hE);
        check("awlate one B", 32'(n_b - nb0), 32'd1);
        aw_dly = 0; w_dly = 3; nb0 = n_b;
        e = predict(1'b1, 32'h0C, 32'h0BADBEEF, 4'hF);
        run_check("wlate", 1'b1, 32'h0C, 32'h0BADBEEF, 4'hF, e, 2'b00, 6);
        check("wlate aw drop", 32'({av_hist[1], av_hist[2]}), 32'd2);
        check("wlate w hold", 32'({wv_hist[2], wv_hist[3], wv_hist[4], wv_hist[5]}), 32'hE);
        check("wlate one B", 32'(n_b - nb0), 32'd1);
        w_dly = 0;

        // Read backpressure with SLVERR
        r_dly = 5; r_resp_cfg = 2'b10; r_force_en = 1'b1; r_force_data = 32'h12345678;
        run_check("rderr", 1'b0, 32'h10, 0, 0, 32'h12345678, 2'b10, 8);
        check("rderr rready", 32'(v_rready), 32'd0);
        check("rderr cmd_ready", 32'(v_cmdrdy), 32'd0);
        r_dly = 0; r_resp_cfg = 2'b00; r_force_en = 1'b0;

        // Back-to-back with cmd_valid held high
        bw[0] = 1; ba[0] = 32'h20; bd[0] = 32'h01020304; bs[0] = 4'hF;
        bw[1] = 0; ba[1] = 32'h20; bd[1] = 0;            bs[1] = 4'h0;
        bw[2] = 1; ba[2] = 32'h20; bd[2] = 32'hF0E0D0C0; bs[2] = 4'h3;
        bw[3] = 0; ba[3] = 32'h20; bd[3] = 0;            bs[3] = 4'h0;
        begin
            int idx = 0, n_acc = 0, n_rsp = 0;
            logic pend = 0;
            cmd_write = bw[0]; cmd_addr = ba[0]; cmd_wdata = bd[0]; cmd_wstrb = bs[0];
            cmd_valid = 1'b1;
            for (int c = 0; c < 100 && n_rsp < 4; c++) begin
                if (cmd_valid && cmd_ready) begin
                    eq_rdata.push_back(predict(cmd_write, cmd_addr, cmd_wdata, cmd_wstrb));
                    eq_resp.push_back(2'b00);
                    pend = 1; n_acc++;
                end
                tick();
                if (pend) begin
                    pend = 0; idx++;
                    if (idx < 4) begin
                        cmd_write = bw[idx]; cmd_addr = ba[idx];
                        cmd_wdata = bd[idx]; cmd_wstrb = bs[idx];
                    end else cmd_valid = 1'b0;
                end
                if (resp_valid) begin
                    n_rsp++;
                    if (eq_rdata.size() > 0) begin
                        check("b2b rdata", resp_rdata, eq_rdata.pop_front());
                        check("b2b resp", 32'(resp_resp), 32'(eq_resp.pop_front()));
                    end else check("b2b extra resp", 32'(n_rsp), 32'(n_acc));
                end
            end
            cmd_valid = 1'b0;
            check("b2b accepts", 32'(n_acc), 32'd4);
            check("b2b resps", 32'(n_rsp), 32'd4);
            check("b2b last rd", ref_rd(32'h20), 32'h0102D0C0);
        end

        // Reset in the middle of a stalled write
        aw_dly = 20;
        while (!cmd_ready) tick();
        cmd_write = 1; cmd_addr = 32'h30; cmd_wdata = 32'h55555555; cmd_wstrb = 4'hF;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("mid aw pending", 32'({m_axi_awvalid, m_axi_awready}), 32'd2);
        tick();
        aresetn = 1'b0;
        tick();
        check("mid valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                                 m_axi_rready}), 32'd0);
        check("mid cmd_ready", 32'(cmd_ready), 32'd0);
        check("mid no resp", 32'(resp_valid), 32'd0);
        aw_dly = 0;
        aresetn = 1'b1;
        tick();
        check("post rst cmd_ready", 32'(cmd_ready), 32'd1);
        e = predict(1'b1, 32'h34, 32'h600DF00D, 4'hF);
        run_check("post wr", 1'b1, 32'h34, 32'h600DF00D, 4'hF, e, 2'b00, 3);
        run_check("post rd30", 1'b0, 32'h30, 0, 0, ref_rd(32'h30), 2'b00, 3);

        // Randomized commands, wait states and response codes
        for (int i = 0; i < 30; i++) begin
            rw = 1'($urandom_range(0, 1));
            ra = 32'($urandom_range(0, 7)) * 4;
            rd = $urandom;
            rs = 4'($urandom_range(0, 15));
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
            b_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
            r_dly = $urandom_range(0, 3);
            b_resp_cfg = 2'($urandom_range(0, 3)); r_resp_cfg = 2'($urandom_range(0, 3));
            e = predict(rw, ra, rd, rs);
            if (rw)
                run_check("rand wr", 1'b1, ra, rd, rs, e, b_resp_cfg,
                          3 + (aw_dly > w_dly ? aw_dly : w_dly) + b_dly);
            else
                run_check("rand rd", 1'b0, ra, rd, rs, e, r_resp_cfg, 3 + ar_dly + r_dly);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
